// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update path: queued update record and arbiter FSM states.
package bp_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    logic        mispredict;
  } bp_update_t;

  localparam int UPD_W = $bits(bp_update_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STALL = 2'd2
  } bp_state_e;

endpackage

// File: rtl/bp_upd_fifo.sv
// 2-write/1-read circular buffer of predictor updates; writes visible at head one cycle later.
// No internal backpressure: the caller must only write into free slots (it arbitrates on count).
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wr0_en,
  input  logic [UPD_W-1:0]           wr0_dat,
  input  logic                       wr1_en,
  input  logic [UPD_W-1:0]           wr1_dat,
  input  logic                       rd_en,
  output logic [UPD_W-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [$clog2(DEPTH+1)-1:0] count_nxt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [UPD_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    n_push;
  logic [PW-1:0]    wr1_addr;

  assign n_push    = CW'(wr0_en) + CW'(wr1_en);
  assign count_nxt = clear ? '0 : (count_q + n_push - CW'(rd_en));
  // wr1 lands behind wr0 when both write, keeping req0 ahead of req1.
  assign wr1_addr  = wr0_en ? (wptr_q + PW'(1)) : wptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_q + PW'(n_push);
      if (rd_en) rptr_q <= rptr_q + PW'(1);
      count_q <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wptr_q]   <= wr0_dat;
    if (wr1_en) mem[wr1_addr] <= wr1_dat;
  end

  assign head_dat = (count_q == '0) ? '0 : mem[rptr_q];
  assign count    = count_q;

endmodule

// File: rtl/bp_update_arb.sv
// Merges branch-unit and jump-unit resolutions into one predictor update stream; 1-cycle enqueue-to-head.
// Ready derives from registered occupancy (round-robin at one free slot); hold pauses drain, flush drops all.
module bp_update_arb
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [31:0]                req0_pc,
  input  logic [31:0]                req0_target,
  input  logic                       req0_taken,
  input  logic                       req0_mispredict,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [31:0]                req1_pc,
  input  logic [31:0]                req1_target,
  input  logic                       req1_taken,
  input  logic                       req1_mispredict,
  output logic                       upd_valid,
  output logic [31:0]                upd_pc,
  output logic [31:0]                upd_target,
  output logic                       upd_taken,
  output logic                       upd_mispredict,
  input  logic                       hold,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 state
);

  localparam int CW = $clog2(DEPTH+1);

  bp_update_t    wr0;
  bp_update_t    wr1;
  bp_update_t    head;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] free;
  logic          push0;
  logic          push1;
  logic          pop;
  logic          rr_q;
  logic          rr_d;
  bp_state_e     state_q;
  bp_state_e     state_d;

  assign wr0 = '{pc: req0_pc, target: req0_target, taken: req0_taken, mispredict: req0_mispredict};
  assign wr1 = '{pc: req1_pc, target: req1_target, taken: req1_taken, mispredict: req1_mispredict};

  assign free = CW'(DEPTH) - count_q;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!flush) begin
      if (free >= CW'(2)) begin
        req0_ready = 1'b1;
        req1_ready = 1'b1;
      end else if (free == CW'(1)) begin
        // The favoured requester owns the last slot; the other may only use it when idle.
        if (!rr_q) begin
          req0_ready = 1'b1;
          req1_ready = !req0_valid;
        end else begin
          req1_ready = 1'b1;
          req0_ready = !req1_valid;
        end
      end
    end
  end

  assign push0 = req0_valid && req0_ready;
  assign push1 = req1_valid && req1_ready;
  assign pop   = (count_q != '0) && !hold && !flush;
  assign rr_d  = rr_q ^ (req0_valid && req1_valid && (push0 ^ push1));

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .wr0_en    (push0),
    .wr0_dat   (wr0),
    .wr1_en    (push1),
    .wr1_dat   (wr1),
    .rd_en     (pop),
    .head_dat  (head),
    .count     (count_q),
    .count_nxt (count_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      rr_q    <= rr_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_DRAIN;
    if (flush)                  state_d = ST_IDLE;
    else if (count_nxt == '0)   state_d = ST_IDLE;
    else if (hold)              state_d = ST_STALL;
  end

  assign upd_valid      = pop;
  assign upd_pc         = head.pc;
  assign upd_target     = head.target;
  assign upd_taken      = head.taken;
  assign upd_mispredict = head.mispredict;
  assign count          = count_q;
  assign state          = state_q;

endmodule

// File: tb/tb_bp_update_arb.sv
// Directed bench: stimulus pushes expected updates into a queue, a negedge monitor pops and compares.
module tb_bp_update_arb;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready, req0_taken, req0_mispredict;
  logic [31:0] req0_pc, req0_target;
  logic        req1_valid, req1_ready, req1_taken, req1_mispredict;
  logic [31:0] req1_pc, req1_target;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic        hold, flush;
  logic [2:0]  count;
  logic [1:0]  state;

  int          checks = 0;
  int          errors = 0;
  bp_update_t  exp_q[$];
  bp_update_t  mon_e;
  logic [31:0] ord [4];

  always #5 clk = ~clk;

  bp_update_arb #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc),
    .req0_target(req0_target), .req0_taken(req0_taken), .req0_mispredict(req0_mispredict),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc),
    .req1_target(req1_target), .req1_taken(req1_taken), .req1_mispredict(req1_mispredict),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .hold(hold), .flush(flush), .count(count), .state(state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bp_update_t mk(input logic [31:0] pc, input logic [31:0] tgt,
                                    input logic tk, input logic mp);
    bp_update_t u;
    u = '{pc: pc, target: tgt, taken: tk, mispredict: mp};
    return u;
  endfunction

  function automatic bp_update_t mkp(input logic [31:0] pc);
    return mk(pc, pc + 32'h0001_0000, pc[2], pc[3]);
  endfunction

  task automatic set0(input logic v, input bp_update_t u);
    req0_valid = v; req0_pc = u.pc; req0_target = u.target;
    req0_taken = u.taken; req0_mispredict = u.mispredict;
  endtask

  task automatic set1(input logic v, input bp_update_t u);
    req1_valid = v; req1_pc = u.pc; req1_target = u.target;
    req1_taken = u.taken; req1_mispredict = u.mispredict;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && upd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got pc 0x%0h expected no update", upd_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_pc_target", {upd_pc, upd_target}, {mon_e.pc, mon_e.target});
        chk("mon_flags", {62'd0, upd_taken, upd_mispredict}, {62'd0, mon_e.taken, mon_e.mispredict});
      end
    end
  end

  initial begin
    set0(1'b0, mkp(32'h0)); set1(1'b0, mkp(32'h0));
    hold = 1'b0; flush = 1'b0;

    // reset state
    #2;
    chk("rst_count", count, 0);
    chk("rst_ready0", req0_ready, 1);
    chk("rst_ready1", req1_ready, 1);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_upd_pc", upd_pc, 0);
    chk("rst_state", state, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    neg();
    chk("post_rst_ready", {req0_ready, req1_ready}, 2'b11);

    // single req0 update flows through
    nxt();
    set0(1'b1, mk(32'h100, 32'h200, 1'b1, 1'b0));
    exp_q.push_back(mk(32'h100, 32'h200, 1'b1, 1'b0));
    neg();
    chk("t1_ready0", req0_ready, 1);
    nxt();
    set0(1'b0, mkp(32'h0));
    neg();
    chk("t1_count", count, 1);
    chk("t1_state", state, 1);
    chk("t1_upd_valid", upd_valid, 1);
    chk("t1_upd_pc", upd_pc, 32'h100);
    chk("t1_upd_target", upd_target, 32'h200);
    nxt();
    neg();
    chk("t1_count_end", count, 0);
    chk("t1_state_end", state, 0);
    chk("t1_upd_valid_end", upd_valid, 0);

    // fill under hold, then drain in order
    nxt();
    hold = 1'b1;
    set0(1'b1, mkp(32'h1000)); set1(1'b1, mkp(32'h2000));
    exp_q.push_back(mkp(32'h1000)); exp_q.push_back(mkp(32'h2000));
    neg();
    chk("t2_ready_both0", {req0_ready, req1_ready}, 2'b11);
    nxt();
    set0(1'b1, mkp(32'h1004)); set1(1'b1, mkp(32'h2004));
    exp_q.push_back(mkp(32'h1004)); exp_q.push_back(mkp(32'h2004));
    neg();
    chk("t2_count2", count, 2);
    chk("t2_ready_both1", {req0_ready, req1_ready}, 2'b11);
    nxt();
    set0(1'b0, mkp(32'h0)); set1(1'b0, mkp(32'h0));
    neg();
    chk("t2_count_full", count, 4);
    chk("t2_ready_full", {req0_ready, req1_ready}, 2'b00);
    chk("t2_state_stall", state, 2);
    chk("t2_upd_valid_hold", upd_valid, 0);
    nxt();
    hold = 1'b0;
    ord = '{32'h1000, 32'h2000, 32'h1004, 32'h2004};
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("t2_drain_valid", upd_valid, 1);
      chk("t2_drain_pc", upd_pc, ord[i]);
      nxt();
    end
    neg();
    chk("t2_count_end", count, 0);
    chk("t2_state_end", state, 0);

    // round-robin at one free slot
    nxt();
    hold = 1'b1;
    set0(1'b1, mkp(32'h3000)); set1(1'b1, mkp(32'h4000));
    exp_q.push_back(mkp(32'h3000)); exp_q.push_back(mkp(32'h4000));
    nxt();
    set0(1'b1, mkp(32'h3004)); set1(1'b0, mkp(32'h0));
    exp_q.push_back(mkp(32'h3004));
    nxt();
    set0(1'b1, mkp(32'h3008)); set1(1'b1, mkp(32'h4008));
    exp_q.push_back(mkp(32'h3008));
    neg();
    chk("t3_count3", count, 3);
    chk("t3_rr0_ready", {req0_ready, req1_ready}, 2'b10);
    nxt();
    set0(1'b0, mkp(32'h0)); set1(1'b0, mkp(32'h0));
    hold = 1'b0;
    neg();
    chk("t3_count4", count, 4);
    chk("t3_pop_pc", upd_pc, 32'h3000);
    nxt();
    hold = 1'b1;
    set0(1'b1, mkp(32'h300c)); set1(1'b1, mkp(32'h400c));
    exp_q.push_back(mkp(32'h400c));
    neg();
    chk("t3_count3b", count, 3);
    chk("t3_rr1_ready", {req0_ready, req1_ready}, 2'b01);
    nxt();
    set0(1'b0, mkp(32'h0)); set1(1'b0, mkp(32'h0));
    neg();
    chk("t3_count4b", count, 4);
    nxt();
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("t3_drain_valid", upd_valid, 1);
      nxt();
    end
    neg();
    chk("t3_count_end", count, 0);

    // simultaneous push and pop at count 2
    nxt();
    hold = 1'b1;
    set0(1'b1, mkp(32'h5000)); set1(1'b1, mkp(32'h6000));
    exp_q.push_back(mkp(32'h5000)); exp_q.push_back(mkp(32'h6000));
    nxt();
    hold = 1'b0;
    set0(1'b1, mkp(32'h5004)); set1(1'b0, mkp(32'h0));
    exp_q.push_back(mkp(32'h5004));
    neg();
    chk("t4_count_before", count, 2);
    chk("t4_pop_pc", upd_pc, 32'h5000);
    chk("t4_ready0", req0_ready, 1);
    nxt();
    set0(1'b0, mkp(32'h0));
    hold = 1'b1;
    neg();
    chk("t4_count_after", count, 2);
    chk("t4_head_pc", upd_pc, 32'h6000);
    chk("t4_upd_valid_hold", upd_valid, 0);
    nxt();
    hold = 1'b0;
    neg(); nxt(); neg(); nxt();
    neg();
    chk("t4_count_end", count, 0);
    chk("t4_all_delivered", exp_q.size(), 0);

    // flush with a live offer
    nxt();
    hold = 1'b1;
    set0(1'b1, mkp(32'h7000)); set1(1'b1, mkp(32'h8000));
    exp_q.push_back(mkp(32'h7000)); exp_q.push_back(mkp(32'h8000));
    nxt();
    set0(1'b1, mkp(32'h7004)); set1(1'b0, mkp(32'h0));
    exp_q.push_back(mkp(32'h7004));
    nxt();
    set0(1'b1, mkp(32'h7ff0));
    flush = 1'b1;
    hold = 1'b0;
    neg();
    chk("t5_count3", count, 3);
    chk("t5_ready_flush", {req0_ready, req1_ready}, 2'b00);
    chk("t5_upd_valid_flush", upd_valid, 0);
    nxt();
    flush = 1'b0;
    set0(1'b0, mkp(32'h0));
    exp_q.delete();
    neg();
    chk("t5_count_after", count, 0);
    chk("t5_state_after", state, 0);
    chk("t5_upd_pc_after", upd_pc, 0);
    chk("t5_ready_after", {req0_ready, req1_ready}, 2'b11);
    nxt();
    neg();
    chk("t5_upd_valid_idle", upd_valid, 0);

    // asynchronous reset mid-occupancy
    nxt();
    hold = 1'b1;
    set0(1'b1, mkp(32'h9000)); set1(1'b1, mkp(32'ha000));
    nxt();
    set0(1'b1, mkp(32'h9004)); set1(1'b0, mkp(32'h0));
    nxt();
    set0(1'b0, mkp(32'h0));
    neg();
    chk("t6_count3", count, 3);
    #2;
    rst = 1'b1;
    hold = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_async_count", count, 0);
    chk("t6_async_upd_valid", upd_valid, 0);
    chk("t6_async_state", state, 0);
    chk("t6_async_upd_pc", upd_pc, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    neg();
    chk("t6_post_count", count, 0);
    chk("t6_post_ready", {req0_ready, req1_ready}, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
